// File: rtl/pwm_frame_loader_if.sv
// ---------------------------------------------------------------------------
// pwm_frame_loader_if
// Bundles the byte-stream input, the PWM period marker and the loader's
// outputs into one interface.
//   rx_data      : received byte, qualified by new_rx_data
//   new_rx_data  : one-cycle strobe, one byte per high cycle
//   period_start : one-cycle pulse when the PWM counter wraps to 0
//   duty         : live duty values, channel n at [8n+7:8n]
//   busy         : a frame is being received or is waiting to commit
//   commit       : one-cycle pulse in the cycle duty takes a new frame
//   frame_err    : one-cycle pulse on checksum error, timeout or overrun
//   err_count    : saturating count of frame_err pulses
// Modports: master drives the stream (RX + PWM side), slave is the loader.
// ---------------------------------------------------------------------------
interface pwm_frame_loader_if #(
  parameter int unsigned NUM_CH = 10
);
  logic [7:0]          rx_data;
  logic                new_rx_data;
  logic                period_start;
  logic [8*NUM_CH-1:0] duty;
  logic                busy;
  logic                commit;
  logic                frame_err;
  logic [7:0]          err_count;

  modport master (
    output rx_data,
    output new_rx_data,
    output period_start,
    input  duty,
    input  busy,
    input  commit,
    input  frame_err,
    input  err_count
  );

  modport slave (
    input  rx_data,
    input  new_rx_data,
    input  period_start,
    output duty,
    output busy,
    output commit,
    output frame_err,
    output err_count
  );
endinterface

// File: rtl/pwm_frame_loader.sv
// ---------------------------------------------------------------------------
// pwm_frame_loader
// Parses SYNC / D0..D(NUM_CH-1) / CHK frames from the serial RX byte stream
// into a staging buffer. A frame whose XOR checksum matches is held pending
// and copied into the live duty registers on the next PWM period_start, so
// every channel switches in the same period.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pwm_frame_loader_if.slave (stream in, duty/status out)
// ---------------------------------------------------------------------------

// Property checker for the loader outputs; kept apart from the datapath.
module pwm_frame_loader_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       commit,
  input logic       busy,
  input logic       frame_err,
  input logic [7:0] err_count
);
  // A commit always ends the frame, so busy is already low in that cycle.
  a_commit_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    commit |-> !busy);

  // An error pulse is always accompanied by a nonzero error count.
  a_err_counted: assert property (@(posedge clk) disable iff (!rst_n)
    frame_err |-> (err_count != 8'd0));
endmodule

module pwm_frame_loader #(
  parameter int unsigned NUM_CH         = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst_n,
  pwm_frame_loader_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  // The counter value that becomes TIMEOUT_CYCLES on the next idle clock.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK  = 2'd2,
    ST_PEND = 2'd3
  } state_t;

  // Running frame checksum: plain byte-wise XOR.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                    state_r;
  state_t                    state_next_s;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          idx_next_s;
  logic [7:0]                xor_r;
  logic [7:0]                xor_next_s;
  logic [TO_W-1:0]           to_cnt_r;
  logic [TO_W-1:0]           to_next_s;
  logic [NUM_CH-1:0][7:0]    staging_r;
  logic [NUM_CH-1:0][7:0]    staging_next_s;
  logic [8*NUM_CH-1:0]       duty_r;
  logic [8*NUM_CH-1:0]       duty_next_s;
  logic                      commit_r;
  logic                      commit_s;
  logic                      frame_err_r;
  logic                      frame_err_s;
  logic                      busy_r;
  logic                      busy_next_s;
  logic [7:0]                err_count_r;
  logic [7:0]                err_count_next_s;

  logic                      rx_valid_s;
  logic [7:0]                rx_byte_s;

  assign rx_valid_s = bus.new_rx_data;
  assign rx_byte_s  = bus.rx_data;

  // Next-state, staging, checksum, timeout and flag decode.
  always_comb begin
    state_next_s   = state_r;
    idx_next_s     = idx_r;
    xor_next_s     = xor_r;
    staging_next_s = staging_r;
    duty_next_s    = duty_r;
    to_next_s      = {TO_W{1'b0}};
    commit_s       = 1'b0;
    frame_err_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Only the marker opens a frame; other bytes vanish without an error.
        if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
          state_next_s = ST_DATA;
          idx_next_s   = {IDX_W{1'b0}};
          xor_next_s   = 8'h00;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_DATA: begin
        // Inside a frame every byte is data, including one equal to the marker.
        if (rx_valid_s) begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (idx_r == IDX_W'(i)) begin
              staging_next_s[i] = rx_byte_s;
            end else begin
              staging_next_s[i] = staging_r[i];
            end
          end
          xor_next_s = chk_fold(xor_r, rx_byte_s);
          if (idx_r == IDX_LAST) begin
            state_next_s = ST_CHK;
            idx_next_s   = {IDX_W{1'b0}};
          end else begin
            idx_next_s   = idx_r + IDX_W'(1);
          end
        end else if (to_cnt_r == TO_LAST) begin
          frame_err_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          to_next_s = to_cnt_r + TO_W'(1);
        end
      end

      ST_CHK: begin
        if (rx_valid_s) begin
          if (rx_byte_s == xor_r) begin
            state_next_s = ST_PEND;
          end else begin
            frame_err_s  = 1'b1;
            state_next_s = ST_IDLE;
          end
        end else if (to_cnt_r == TO_LAST) begin
          frame_err_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          to_next_s = to_cnt_r + TO_W'(1);
        end
      end

      ST_PEND: begin
        // period_start only counts here, so a CHK accepted together with
        // period_start always waits for the following period.
        if (bus.period_start) begin
          duty_next_s  = staging_r;
          commit_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PEND;
        end
        // Overrun: the byte is dropped, the pending frame stays intact.
        if (rx_valid_s) begin
          frame_err_s = 1'b1;
        end else begin
          frame_err_s = 1'b0;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);

    if (frame_err_s && (err_count_r != 8'hFF)) begin
      err_count_next_s = err_count_r + 8'd1;
    end else begin
      err_count_next_s = err_count_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      xor_r       <= 8'h00;
      to_cnt_r    <= {TO_W{1'b0}};
      staging_r   <= {(8*NUM_CH){1'b0}};
      duty_r      <= {(8*NUM_CH){1'b0}};
      commit_r    <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      xor_r       <= xor_next_s;
      to_cnt_r    <= to_next_s;
      staging_r   <= staging_next_s;
      duty_r      <= duty_next_s;
      commit_r    <= commit_s;
      frame_err_r <= frame_err_s;
      busy_r      <= busy_next_s;
      err_count_r <= err_count_next_s;
    end
  end

  assign bus.duty      = duty_r;
  assign bus.busy      = busy_r;
  assign bus.commit    = commit_r;
  assign bus.frame_err = frame_err_r;
  assign bus.err_count = err_count_r;

  pwm_frame_loader_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit_r),
    .busy      (busy_r),
    .frame_err (frame_err_r),
    .err_count (err_count_r)
  );

endmodule

// File: tb/tb_pwm_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_pwm_frame_loader
// Directed bench: a per-cycle vector table for a good and a bad-checksum
// frame, then hand-written sequences for timeout, marker-valued data,
// CHK/period_start coincidence, PEND overrun and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_pwm_frame_loader;

  localparam int         NCH  = 10;
  localparam int         CW   = 8 * NCH;
  localparam int         TO   = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pwm_frame_loader_if #(.NUM_CH(NCH)) bus ();

  pwm_frame_loader #(
    .NUM_CH         (NCH),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          strb;
    logic [7:0]    data;
    logic          ps;
    logic          busy;
    logic          commit;
    logic          err;
    logic [7:0]    cnt;
    logic [CW-1:0] duty;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [CW-1:0] duty_a;
  logic [CW-1:0] duty_b;
  logic [CW-1:0] duty_c;
  logic [7:0]    exp_errs;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic busy, input logic commit,
                            input logic err, input logic [7:0] cnt, input logic [CW-1:0] duty);
    check({tag, ".busy"},      CW'(bus.busy),      CW'(busy));
    check({tag, ".commit"},    CW'(bus.commit),    CW'(commit));
    check({tag, ".frame_err"}, CW'(bus.frame_err), CW'(err));
    check({tag, ".err_count"}, CW'(bus.err_count), CW'(cnt));
    check({tag, ".duty"},      bus.duty,           duty);
  endtask

  // One clock of stimulus; outputs are read 1 ns after the edge.
  task automatic cyc(input logic strb, input logic [7:0] data, input logic ps);
    bus.new_rx_data  = strb;
    bus.rx_data      = data;
    bus.period_start = ps;
    @(posedge clk);
    #1;
    bus.new_rx_data  = 1'b0;
    bus.rx_data      = 8'h00;
    bus.period_start = 1'b0;
  endtask

  function automatic void add(input logic strb, input logic [7:0] data, input logic ps,
                              input logic busy, input logic commit, input logic err,
                              input logic [7:0] cnt, input logic [CW-1:0] duty);
    vec_t v;
    v.strb = strb; v.data = data; v.ps = ps;
    v.busy = busy; v.commit = commit; v.err = err; v.cnt = cnt; v.duty = duty;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] frame_xor(input logic [CW-1:0] d);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NCH; i++) x = x ^ d[8*i +: 8];
    return x;
  endfunction

  initial begin
    logic [CW-1:0] zero;
    logic [7:0]    gb [3];
    int            waited;

    zero  = {CW{1'b0}};
    gb[0] = 8'h12; gb[1] = 8'h34; gb[2] = 8'h56;
    for (int i = 0; i < NCH; i++) begin
      duty_a[8*i +: 8] = 8'(16 * i);
      duty_c[8*i +: 8] = 8'(3 + 37 * i);
    end
    // Frame B carries the marker value twice as ordinary duty data.
    duty_b = {8'h56, 8'h34, 8'h12, 8'hFF, 8'h00, 8'hA5, 8'h33, 8'h5A, 8'hA5, 8'h01};

    bus.rx_data      = 8'h00;
    bus.new_rx_data  = 1'b0;
    bus.period_start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0, zero);
    rst_n = 1'b1;

    // ---- table: garbage, frame A (CHK 8'h10 by hand), commit, bad frame ----
    for (int i = 0; i < 3; i++) add(1'b1, gb[i], 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, zero);
    add(1'b1, SYNC, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, zero);
    for (int i = 0; i < NCH; i++) add(1'b1, duty_a[8*i +: 8], 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, zero);
    add(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, zero);
    for (int i = 0; i < 19; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, zero);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, duty_a);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, duty_a);
    add(1'b1, SYNC, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, duty_a);
    for (int i = 0; i < NCH; i++) add(1'b1, duty_a[8*i +: 8], 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, duty_a);
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, duty_a);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, duty_a);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, duty_a);

    foreach (vecs[i]) begin
      cyc(vecs[i].strb, vecs[i].data, vecs[i].ps);
      check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].commit, vecs[i].err,
                 vecs[i].cnt, vecs[i].duty);
    end
    exp_errs = 8'd1;

    // ---- timeout after D3 ----
    cyc(1'b1, SYNC, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, duty_b[8*i +: 8], 1'b0);
    waited = 0;
    for (int k = 1; k <= 3 * TO; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (bus.frame_err) begin
        waited = k;
        break;
      end
    end
    exp_errs = exp_errs + 8'd1;
    check("timeout.cycles", CW'(waited), CW'(TO));
    check("timeout.busy", CW'(bus.busy), CW'(1'b0));
    check("timeout.err_count", CW'(bus.err_count), CW'(exp_errs));
    check("timeout.duty", bus.duty, duty_a);

    // ---- garbage, then frame B with marker-valued data ----
    for (int i = 0; i < 3; i++) cyc(1'b1, gb[i], 1'b0);
    check_outs("garbage", 1'b0, 1'b0, 1'b0, exp_errs, duty_a);
    cyc(1'b1, SYNC, 1'b0);
    for (int i = 0; i < NCH; i++) cyc(1'b1, duty_b[8*i +: 8], 1'b0);
    cyc(1'b1, frame_xor(duty_b), 1'b0);
    check_outs("b.pend", 1'b1, 1'b0, 1'b0, exp_errs, duty_a);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check_outs("b.commit", 1'b0, 1'b1, 1'b0, exp_errs, duty_b);
    cyc(1'b0, 8'h00, 1'b0);
    check_outs("b.after", 1'b0, 1'b0, 1'b0, exp_errs, duty_b);

    // ---- frame C: CHK with period_start, overrun, byte+period_start ----
    cyc(1'b1, SYNC, 1'b0);
    for (int i = 0; i < NCH; i++) cyc(1'b1, duty_c[8*i +: 8], 1'b0);
    cyc(1'b1, frame_xor(duty_c), 1'b1);
    check_outs("c.chk_ps", 1'b1, 1'b0, 1'b0, exp_errs, duty_b);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0);
    exp_errs = exp_errs + 8'd1;
    check_outs("c.overrun", 1'b1, 1'b0, 1'b1, exp_errs, duty_b);
    cyc(1'b1, 8'h77, 1'b1);
    exp_errs = exp_errs + 8'd1;
    check_outs("c.coincide", 1'b0, 1'b1, 1'b1, exp_errs, duty_c);
    cyc(1'b0, 8'h00, 1'b0);
    check_outs("c.after", 1'b0, 1'b0, 1'b0, exp_errs, duty_c);

    // ---- asynchronous reset while D5 is on the bus ----
    cyc(1'b1, SYNC, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, duty_a[8*i +: 8], 1'b0);
    bus.new_rx_data = 1'b1;
    bus.rx_data     = duty_a[47:40];
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 1'b0, 8'd0, zero);
    bus.new_rx_data = 1'b0;
    bus.rx_data     = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_errs = 8'd0;
    cyc(1'b1, SYNC, 1'b0);
    for (int i = 0; i < NCH; i++) cyc(1'b1, duty_a[8*i +: 8], 1'b0);
    cyc(1'b1, frame_xor(duty_a), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check_outs("post_rst.pend", 1'b1, 1'b0, 1'b0, exp_errs, zero);
    cyc(1'b0, 8'h00, 1'b1);
    check_outs("post_rst.commit", 1'b0, 1'b1, 1'b0, exp_errs, duty_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
